branch_hazard_unit: RTL and testbench
=====================================

Name: branch_hazard_unit

Overview:
Parametrised successor of the ID-stage branch hazard detector for the pipelined MIPS core. It detects register dependencies of ID-stage control transfers on EX and MEM producers, including multi-cycle loads gated by a memory-ready signal. A small FSM holds the stall, generates a multi-cycle redirect flush of IF/ID, runs a stall watchdog and keeps saturating stall/flush counters. It sits beside the main hazard unit; its stall/flush outputs are ORed into the pipeline register controls.

Parameters:
REG_AW, 5, register address width; address 0 is never a hazard source
REDIRECT_CYCLES, 1, cycles flush_d is held after a resolved transfer (1..15)
MAX_STALL, 16, stall cycles before the watchdog flags err (>=2)
CNT_W, 16, width of the performance counters

Ports:
clk  in  1  core clock
rst_n  in  1  synchronous active-low reset
id_valid  in  1  ID holds a real instruction
id_rs  in  REG_AW  ID source register 1
id_rt  in  REG_AW  ID source register 2
id_jmp_need_reg  in  1  ID transfer reads registers (beq/bne/jr)
id_jmp_imm  in  1  ID is j/jal
id_jmp_reg  in  1  ID is jr
id_jmp_branch  in  1  ID is a taken branch
ex_regwe  in  1  EX writes the register file
ex_rw  in  REG_AW  EX destination
mem_ramtoreg  in  1  MEM is a load
mem_rw  in  REG_AW  MEM destination
mem_ready  in  1  MEM load data is available this cycle
stall_ext  in  1  global freeze (cache miss etc.)
stall_f  out  1  hold PC
stall_d  out  1  hold IF/ID
flush_e  out  1  inject bubble into ID/EX
flush_d  out  1  flush IF/ID
err  out  1  sticky watchdog flag
stall_cnt  out  CNT_W  saturating count of hazard-stall cycles
flush_cnt  out  CNT_W  saturating count of redirects started

Behaviour:
- Reset (rst_n low at a clk edge): state RUN, redirect counter 0, watchdog counter 0, err 0, both counters 0. Combinational outputs follow from that state.
- Source match: src_hit(x) = x != 0 and (x == id_rs or x == id_rt).
- ex_hit = id_jmp_need_reg and ex_regwe and src_hit(ex_rw).
- mem_hit = id_jmp_need_reg and mem_ramtoreg and src_hit(mem_rw) and not mem_ready.
- hazard = id_valid and (ex_hit or mem_hit). A MEM load with mem_ready=1 is forwarded and is not a hazard.
- transfer = id_valid and (id_jmp_imm or id_jmp_reg or id_jmp_branch).
- stall_f = stall_d = flush_e = hazard, combinational, in the same cycle, in every state. A hazard always wins over flush_d.
- flush_d = (transfer and not hazard) or (state == REDIRECT).
- FSM states: RUN, STALL, REDIRECT. No transition happens while stall_ext = 1; counters also hold.
  - RUN: if hazard, go to STALL. Else if transfer and REDIRECT_CYCLES > 1, go to REDIRECT with the redirect counter set to REDIRECT_CYCLES-1. Otherwise stay in RUN.
  - STALL: the watchdog counter increments each hazard cycle. If hazard clears, clear the watchdog; then go to REDIRECT or RUN using the RUN rules for transfer. If the watchdog reaches MAX_STALL, set err and clear the watchdog (no forced release).
  - REDIRECT: the redirect counter decrements each cycle. When it reaches 0, go to RUN.
- Redirect behaviour: the first flush cycle is the combinational one. REDIRECT adds REDIRECT_CYCLES-1 registered cycles, so the total flush_d width is exactly REDIRECT_CYCLES. In REDIRECT, hazard is still evaluated but ID is a bubble (id_valid = 0).
- Counters: stall_cnt increments each cycle hazard = 1 and stall_ext = 0. flush_cnt increments once per resolved transfer (transfer and not hazard and stall_ext = 0). Both saturate at all-ones with no wrap.
- err stays set until reset. Reset mid-stall or mid-redirect returns to RUN on the next cycle.

Decomposition:
- Shared package: state encoding (RUN/STALL/REDIRECT), plus a REG_ZERO constant.
- One sub-module, sat_counter (CNT_W wide, inc, rst_n, saturating), instantiated twice.
- Matching and FSM logic stay inline.

Test Plan:
- beq rs=3 with ex_regwe=1, ex_rw=3: stall_f = stall_d = flush_e = 1 for one cycle, flush_d = 0. Next cycle (producer now in MEM, not a load) gives flush_d = 1. stall_cnt = 1, flush_cnt = 1.
- jr rt=5 with mem_ramtoreg=1, mem_rw=5, mem_ready=0 for 3 cycles then 1: stall held 3 cycles, then flush_d; stall_cnt = 3.
- ex_rw = 0 with ex_regwe=1 and id_rs = 0: no stall. A j instruction gives flush_d for exactly 1 cycle.
- REDIRECT_CYCLES=3, taken branch with no hazard: flush_d high for 3 consecutive cycles. With stall_ext asserted in cycle 2, flush_d is extended by one cycle.
- MAX_STALL=4, mem_ready held 0 for 6 cycles: err rises at the 4th stall cycle and stays 1. Stall continues until mem_ready = 1.
- stall_cnt preloaded near all-ones via a long stall with CNT_W=4: the counter stops at 15. Pulsing rst_n low mid-REDIRECT clears all counters and flush_d the following cycle.

Source files
------------

// File: rtl/branch_hazard_unit_pkg.sv
// Shared definitions for the ID-stage branch hazard unit.
//   bhu_state_t  : control FSM encoding (RUN / STALL / REDIRECT)
//   REG_ZERO     : the hard-wired zero register, never a hazard source
//   REDIR_CNT_W  : width of the redirect down-counter (REDIRECT_CYCLES <= 15)
package branch_hazard_unit_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_STALL    = 2'd1,
        ST_REDIRECT = 2'd2
    } bhu_state_t;

    localparam int unsigned REG_ZERO    = 0;
    localparam int unsigned REDIR_CNT_W = 4;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: increments on inc, sticks at all-ones.
// Ports: clk, rst_n (synchronous, active-low), inc, count[CNT_W-1:0].
module sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/branch_hazard_unit.sv
// ID-stage branch hazard detector with redirect flush, stall watchdog and
// saturating stall/flush performance counters.
// Ports:
//   clk, rst_n                      : clock, synchronous active-low reset
//   id_*                            : ID-stage instruction decode info
//   ex_regwe/ex_rw                  : EX-stage register producer
//   mem_ramtoreg/mem_rw/mem_ready   : MEM-stage load producer and data ready
//   stall_ext                       : global freeze, holds FSM and counters
//   stall_f/stall_d/flush_e         : hazard stall (combinational)
//   flush_d                         : IF/ID flush for redirects (combinational)
//   err                             : sticky stall watchdog flag
//   stall_cnt/flush_cnt             : saturating performance counters
module branch_hazard_unit
    import branch_hazard_unit_pkg::*;
#(
    parameter int unsigned REG_AW          = 5,
    parameter int unsigned REDIRECT_CYCLES = 1,
    parameter int unsigned MAX_STALL       = 16,
    parameter int unsigned CNT_W           = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_jmp_need_reg,
    input  logic              id_jmp_imm,
    input  logic              id_jmp_reg,
    input  logic              id_jmp_branch,
    input  logic              ex_regwe,
    input  logic [REG_AW-1:0] ex_rw,
    input  logic              mem_ramtoreg,
    input  logic [REG_AW-1:0] mem_rw,
    input  logic              mem_ready,
    input  logic              stall_ext,
    output logic              stall_f,
    output logic              stall_d,
    output logic              flush_e,
    output logic              flush_d,
    output logic              err,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam int unsigned WD_W = $clog2(MAX_STALL + 1);
    localparam logic [WD_W-1:0]        WD_MAX     = WD_W'(MAX_STALL);
    localparam logic [REDIR_CNT_W-1:0] REDIR_INIT = REDIR_CNT_W'(REDIRECT_CYCLES - 1);
    localparam bit                     MULTI      = (REDIRECT_CYCLES > 1);

    function automatic logic src_hit(input logic [REG_AW-1:0] x,
                                     input logic [REG_AW-1:0] rs,
                                     input logic [REG_AW-1:0] rt);
        return (x != REG_AW'(REG_ZERO)) && ((x == rs) || (x == rt));
    endfunction

    logic ex_hit;
    logic mem_hit;
    logic hazard;
    logic transfer;

    bhu_state_t             state_q;
    logic [REDIR_CNT_W-1:0] redir_q;
    logic [WD_W-1:0]        wd_q;
    logic                   err_q;

    // Dependency detection; a ready MEM load is forwarded, so it never stalls.
    assign ex_hit   = id_jmp_need_reg & ex_regwe & src_hit(ex_rw, id_rs, id_rt);
    assign mem_hit  = id_jmp_need_reg & mem_ramtoreg & src_hit(mem_rw, id_rs, id_rt)
                      & ~mem_ready;
    assign hazard   = id_valid & (ex_hit | mem_hit);
    assign transfer = id_valid & (id_jmp_imm | id_jmp_reg | id_jmp_branch);

    // A stall always masks the flush so the held instruction is not lost.
    assign stall_f = hazard;
    assign stall_d = hazard;
    assign flush_e = hazard;
    assign flush_d = ~hazard & (transfer | (state_q == ST_REDIRECT));
    assign err     = err_q;

    // Control FSM: stall tracking with watchdog, and redirect flush extension.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            redir_q <= '0;
            wd_q    <= '0;
            err_q   <= 1'b0;
        end else if (!stall_ext) begin
            unique case (state_q)
                ST_RUN: begin
                    if (hazard) begin
                        state_q <= ST_STALL;
                        wd_q    <= WD_W'(1);
                    end else if (transfer && MULTI) begin
                        state_q <= ST_REDIRECT;
                        redir_q <= REDIR_INIT;
                    end
                end
                ST_STALL: begin
                    if (hazard) begin
                        // Watchdog only flags; the stall is never forcibly released.
                        if ((wd_q + WD_W'(1)) == WD_MAX) begin
                            err_q <= 1'b1;
                            wd_q  <= '0;
                        end else begin
                            wd_q <= wd_q + WD_W'(1);
                        end
                    end else begin
                        wd_q <= '0;
                        if (transfer && MULTI) begin
                            state_q <= ST_REDIRECT;
                            redir_q <= REDIR_INIT;
                        end else begin
                            state_q <= ST_RUN;
                        end
                    end
                end
                ST_REDIRECT: begin
                    redir_q <= redir_q - REDIR_CNT_W'(1);
                    if (redir_q == REDIR_CNT_W'(1)) begin
                        state_q <= ST_RUN;
                    end
                end
                default: begin
                    state_q <= ST_RUN;
                end
            endcase
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (hazard & ~stall_ext),
        .count (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (transfer & ~hazard & ~stall_ext),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_branch_hazard_unit.sv
// Bench for branch_hazard_unit: two configurations driven by identical
// stimulus (A: REDIRECT_CYCLES=1, MAX_STALL=16, CNT_W=16;
// B: REDIRECT_CYCLES=3, MAX_STALL=4, CNT_W=4), directed scenarios with
// literal expectations followed by randomized traffic against a model.
module tb_branch_hazard_unit;

    localparam int RC_A = 1, MS_A = 16, CW_A = 16;
    localparam int RC_B = 3, MS_B = 4,  CW_B = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_valid;
    logic [4:0] id_rs, id_rt;
    logic       id_jmp_need_reg, id_jmp_imm, id_jmp_reg, id_jmp_branch;
    logic       ex_regwe;
    logic [4:0] ex_rw;
    logic       mem_ramtoreg;
    logic [4:0] mem_rw;
    logic       mem_ready;
    logic       stall_ext;

    logic stall_f_a, stall_d_a, flush_e_a, flush_d_a, err_a;
    logic stall_f_b, stall_d_b, flush_e_b, flush_d_b, err_b;
    logic [CW_A-1:0] stall_cnt_a, flush_cnt_a;
    logic [CW_B-1:0] stall_cnt_b, flush_cnt_b;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    branch_hazard_unit #(.REG_AW(5), .REDIRECT_CYCLES(RC_A), .MAX_STALL(MS_A), .CNT_W(CW_A)) dut_a (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_jmp_need_reg(id_jmp_need_reg), .id_jmp_imm(id_jmp_imm), .id_jmp_reg(id_jmp_reg),
        .id_jmp_branch(id_jmp_branch), .ex_regwe(ex_regwe), .ex_rw(ex_rw),
        .mem_ramtoreg(mem_ramtoreg), .mem_rw(mem_rw), .mem_ready(mem_ready),
        .stall_ext(stall_ext), .stall_f(stall_f_a), .stall_d(stall_d_a), .flush_e(flush_e_a),
        .flush_d(flush_d_a), .err(err_a), .stall_cnt(stall_cnt_a), .flush_cnt(flush_cnt_a)
    );

    branch_hazard_unit #(.REG_AW(5), .REDIRECT_CYCLES(RC_B), .MAX_STALL(MS_B), .CNT_W(CW_B)) dut_b (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_jmp_need_reg(id_jmp_need_reg), .id_jmp_imm(id_jmp_imm), .id_jmp_reg(id_jmp_reg),
        .id_jmp_branch(id_jmp_branch), .ex_regwe(ex_regwe), .ex_rw(ex_rw),
        .mem_ramtoreg(mem_ramtoreg), .mem_rw(mem_rw), .mem_ready(mem_ready),
        .stall_ext(stall_ext), .stall_f(stall_f_b), .stall_d(stall_d_b), .flush_e(flush_e_b),
        .flush_d(flush_d_b), .err(err_b), .stall_cnt(stall_cnt_b), .flush_cnt(flush_cnt_b)
    );

    // Per-configuration views of the DUT outputs
    logic        o_sf[2], o_sd[2], o_fe[2], o_fd[2], o_err[2];
    logic [15:0] o_sc[2], o_fc[2];
    assign o_sf[0] = stall_f_a;  assign o_sf[1] = stall_f_b;
    assign o_sd[0] = stall_d_a;  assign o_sd[1] = stall_d_b;
    assign o_fe[0] = flush_e_a;  assign o_fe[1] = flush_e_b;
    assign o_fd[0] = flush_d_a;  assign o_fd[1] = flush_d_b;
    assign o_err[0] = err_a;     assign o_err[1] = err_b;
    assign o_sc[0] = stall_cnt_a;        assign o_sc[1] = 16'(stall_cnt_b);
    assign o_fc[0] = flush_cnt_a;        assign o_fc[1] = 16'(flush_cnt_b);

    function automatic int rc(input int k);   return (k == 0) ? RC_A : RC_B; endfunction
    function automatic int ms(input int k);   return (k == 0) ? MS_A : MS_B; endfunction
    function automatic int cmax(input int k); return (k == 0) ? ((1 << CW_A) - 1) : ((1 << CW_B) - 1); endfunction

    // Behavioural model: flush cycles still owed, consecutive stall length,
    // sticky error and plain integer counters.
    int m_rem[2], m_wd[2], m_sc[2], m_fc[2];
    bit m_err[2];

    function automatic bit hit(input logic [4:0] x);
        return (x != 5'd0) && ((x == id_rs) || (x == id_rt));
    endfunction

    function automatic bit m_hz();
        return id_valid && id_jmp_need_reg &&
               ((ex_regwe && hit(ex_rw)) || (mem_ramtoreg && hit(mem_rw) && !mem_ready));
    endfunction

    function automatic bit m_tr();
        return id_valid && (id_jmp_imm || id_jmp_reg || id_jmp_branch);
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                m_rem[k] = 0; m_wd[k] = 0; m_sc[k] = 0; m_fc[k] = 0; m_err[k] = 1'b0;
            end else if (!stall_ext) begin
                bit hz, tr;
                hz = m_hz();
                tr = m_tr();
                if (hz && m_sc[k] < cmax(k)) m_sc[k]++;
                if (tr && !hz && m_fc[k] < cmax(k)) m_fc[k]++;
                if (m_rem[k] > 0) begin
                    m_rem[k]--;
                end else if (hz) begin
                    m_wd[k]++;
                    if (m_wd[k] == ms(k)) begin
                        m_err[k] = 1'b1;
                        m_wd[k]  = 0;
                    end
                end else begin
                    m_wd[k] = 0;
                    if (tr) m_rem[k] = rc(k) - 1;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                bit hz, fd;
                hz = m_hz();
                fd = !hz && (m_tr() || (m_rem[k] > 0));
                check($sformatf("model stall_f[%0d]", k), 32'(o_sf[k]), 32'(hz));
                check($sformatf("model stall_d[%0d]", k), 32'(o_sd[k]), 32'(hz));
                check($sformatf("model flush_e[%0d]", k), 32'(o_fe[k]), 32'(hz));
                check($sformatf("model flush_d[%0d]", k), 32'(o_fd[k]), 32'(fd));
                check($sformatf("model err[%0d]", k), 32'(o_err[k]), 32'(m_err[k]));
                check($sformatf("model stall_cnt[%0d]", k), 32'(o_sc[k]), 32'(m_sc[k]));
                check($sformatf("model flush_cnt[%0d]", k), 32'(o_fc[k]), 32'(m_fc[k]));
            end
        end
    end

    task automatic idle();
        rst_n = 1'b1; id_valid = 1'b0; id_rs = '0; id_rt = '0;
        id_jmp_need_reg = 1'b0; id_jmp_imm = 1'b0; id_jmp_reg = 1'b0; id_jmp_branch = 1'b0;
        ex_regwe = 1'b0; ex_rw = '0; mem_ramtoreg = 1'b0; mem_rw = '0; mem_ready = 1'b0;
        stall_ext = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    // Reset takes effect on the edge ending the next cycle
    task automatic do_reset();
        next_cycle();
        rst_n = 1'b0;
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk_en = 1'b1;

        // Reset state
        sample();
        check("rst flush_d", 32'(flush_d_a), 0);
        check("rst stall_f", 32'(stall_f_a), 0);
        check("rst err", 32'(err_a), 0);
        check("rst stall_cnt", 32'(stall_cnt_a), 0);
        check("rst flush_cnt", 32'(flush_cnt_b), 0);

        // beq on an EX producer: one stall cycle, then the flush
        next_cycle();
        id_valid = 1; id_jmp_need_reg = 1; id_jmp_branch = 1; id_rs = 5'd3; id_rt = 5'd7;
        ex_regwe = 1; ex_rw = 5'd3;
        sample();
        check("beq stall_f", 32'(stall_f_a), 1);
        check("beq stall_d", 32'(stall_d_a), 1);
        check("beq flush_e", 32'(flush_e_a), 1);
        check("beq flush_d", 32'(flush_d_a), 0);
        next_cycle();
        id_valid = 1; id_jmp_need_reg = 1; id_jmp_branch = 1; id_rs = 5'd3; id_rt = 5'd7;
        mem_rw = 5'd3;
        sample();
        check("beq resolve flush_d", 32'(flush_d_a), 1);
        check("beq resolve stall_f", 32'(stall_f_a), 0);
        next_cycle();
        sample();
        check("beq stall_cnt", 32'(stall_cnt_a), 1);
        check("beq flush_cnt", 32'(flush_cnt_a), 1);
        check("beq flush_d A done", 32'(flush_d_a), 0);
        check("beq flush_d B ext", 32'(flush_d_b), 1);

        // jr on a pending MEM load
        do_reset();
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            id_valid = 1; id_jmp_need_reg = 1; id_jmp_reg = 1; id_rs = 5'd1; id_rt = 5'd5;
            mem_ramtoreg = 1; mem_rw = 5'd5; mem_ready = (i == 3);
            sample();
            check($sformatf("jr stall_f c%0d", i), 32'(stall_f_a), 32'(i < 3));
            check($sformatf("jr flush_d c%0d", i), 32'(flush_d_a), 32'(i == 3));
        end
        next_cycle();
        sample();
        check("jr stall_cnt", 32'(stall_cnt_a), 3);
        check("jr flush_cnt", 32'(flush_cnt_a), 1);
        check("jr err B", 32'(err_b), 0);

        // Register zero never hazards; j flushes for one cycle
        do_reset();
        next_cycle();
        id_valid = 1; id_jmp_need_reg = 1; id_jmp_reg = 1; ex_regwe = 1;
        sample();
        check("r0 stall_f", 32'(stall_f_a), 0);
        check("r0 flush_d", 32'(flush_d_a), 1);
        next_cycle();
        id_valid = 1; id_jmp_imm = 1;
        sample();
        check("j flush_d", 32'(flush_d_a), 1);
        next_cycle();
        sample();
        check("j flush_d after", 32'(flush_d_a), 0);
        check("j flush_cnt", 32'(flush_cnt_a), 2);
        check("j stall_cnt", 32'(stall_cnt_a), 0);

        // Multi-cycle redirect, then the same with a freeze in cycle 2
        do_reset();
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            if (i == 0) begin
                id_valid = 1; id_jmp_need_reg = 1; id_jmp_branch = 1; id_rs = 5'd2; id_rt = 5'd4;
            end
            sample();
            check($sformatf("redir flush_d c%0d", i), 32'(flush_d_b), 32'(i < 3));
        end
        for (int i = 0; i < 5; i++) begin
            next_cycle();
            if (i == 0) begin
                id_valid = 1; id_jmp_branch = 1;
            end
            if (i == 1) stall_ext = 1;
            sample();
            check($sformatf("redir frz flush_d c%0d", i), 32'(flush_d_b), 32'(i < 4));
        end
        check("redir flush_cnt", 32'(flush_cnt_b), 2);

        // Watchdog: err registers at the end of the 4th stall cycle
        do_reset();
        for (int i = 0; i < 7; i++) begin
            next_cycle();
            id_valid = 1; id_jmp_need_reg = 1; id_jmp_reg = 1; id_rs = 5'd6;
            mem_ramtoreg = 1; mem_rw = 5'd6; mem_ready = (i == 6);
            sample();
            check($sformatf("wd stall_f c%0d", i), 32'(stall_f_b), 32'(i < 6));
            check($sformatf("wd err c%0d", i), 32'(err_b), 32'(i >= 4));
        end
        check("wd flush_d", 32'(flush_d_b), 1);
        check("wd err A", 32'(err_a), 0);
        next_cycle();
        sample();
        check("wd err sticky", 32'(err_b), 1);
        check("wd stall_cnt", 32'(stall_cnt_b), 6);

        // Counter saturation, then reset in the middle of a redirect
        do_reset();
        for (int i = 0; i < 20; i++) begin
            next_cycle();
            id_valid = 1; id_jmp_need_reg = 1; id_jmp_branch = 1; id_rs = 5'd9;
            ex_regwe = 1; ex_rw = 5'd9;
        end
        next_cycle();
        id_valid = 1; id_jmp_branch = 1;
        sample();
        check("sat stall_cnt B", 32'(stall_cnt_b), 15);
        check("sat stall_cnt A", 32'(stall_cnt_a), 20);
        check("sat err B", 32'(err_b), 1);
        next_cycle();
        rst_n = 1'b0;
        sample();
        check("midrst flush_d before", 32'(flush_d_b), 1);
        next_cycle();
        sample();
        check("midrst flush_d", 32'(flush_d_b), 0);
        check("midrst stall_cnt", 32'(stall_cnt_b), 0);
        check("midrst flush_cnt", 32'(flush_cnt_b), 0);
        check("midrst err", 32'(err_b), 0);

        // Randomized traffic on a small register set to force frequent matches
        for (int i = 0; i < 3000; i++) begin
            next_cycle();
            rst_n           = ($urandom_range(0, 199) != 0);
            id_valid        = ($urandom_range(0, 3) != 0);
            id_rs           = 5'($urandom_range(0, 3));
            id_rt           = 5'($urandom_range(0, 3));
            id_jmp_need_reg = 1'($urandom_range(0, 1));
            id_jmp_imm      = ($urandom_range(0, 3) == 0);
            id_jmp_reg      = ($urandom_range(0, 3) == 0);
            id_jmp_branch   = ($urandom_range(0, 3) == 0);
            ex_regwe        = 1'($urandom_range(0, 1));
            ex_rw           = 5'($urandom_range(0, 3));
            mem_ramtoreg    = 1'($urandom_range(0, 1));
            mem_rw          = 5'($urandom_range(0, 3));
            mem_ready       = ($urandom_range(0, 2) == 0);
            stall_ext       = ($urandom_range(0, 7) == 0);
        end
        next_cycle();
        sample();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
